eth_tx_arbiter: RTL

- Packet-granular round-robin arbiter that shares one Ethernet TX header-prepend path between NUM_SRC AXI-Stream requesters, e.g. UDP TX and ARP TX.
- Sits directly upstream of the header-prepend stage.
- Latches each winning source's destination MAC and EtherType at grant time. Drives them as stable per-packet configuration to the prepend stage for the whole packet.
- Never interleaves beats of different packets.

---
 rtl/eth_pkg.sv | 19 +
 rtl/eth_tx_arbiter_if.sv | 18 +
 rtl/rr_priority_pick.sv | 27 ++
 rtl/eth_tx_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: header constants, arbiter state encoding
// and byte-order helper.
package eth_pkg;

   localparam int          ETH_HEADER_BYTES = 14;
   localparam logic [15:0] ETH_TYPE_IPV4    = 16'h0800;
   localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      STREAM = 2'd2
   } arb_state_t;

   function automatic logic [15:0] swap_bytes(input logic [15:0] x);
      return {x[7:0], x[15:8]};
   endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// AXI-Stream bundle carrying N parallel lanes; N=1 for the single output stream.
interface eth_tx_arbiter_if #(
   parameter int DATA_WIDTH = 512,
   parameter int N          = 1
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   logic [N-1:0]            tvalid;
   logic [N*DATA_WIDTH-1:0] tdata;
   logic [N*KEEP_WIDTH-1:0] tkeep;
   logic [N-1:0]            tlast;
   logic [N*2-1:0]          tuser;
   logic [N-1:0]            tready;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input  tready);
   modport slave  (input  tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first requester strictly after 'last', wrapping modulo NUM_SRC.
module rr_priority_pick
   import eth_pkg::*;
#(
   parameter  int NUM_SRC = 2,
   localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   last,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               any_req
);

   int idx;

   // Scan farthest-first so the nearest requester after 'last' overwrites.
   always_comb begin
      gnt_idx = '0;
      any_req = |req;
      idx     = 0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_SRC;
         if (req[idx]) gnt_idx = SRC_W'(idx);
      end
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the Ethernet header-prepend stage;
// latches per-packet MAC/EtherType at grant and never interleaves packets.
//
//   state  | meaning
//   IDLE   | no grant; pick next requester, latch its config
//   GRANT  | one settle cycle, config stable, no data moves
//   STREAM | pass-through of granted source until tlast handshake
module eth_tx_arbiter
   import eth_pkg::*;
#(
   parameter  int DATA_WIDTH = 512,
   parameter  int NUM_SRC    = 2,
   localparam int KEEP_WIDTH = DATA_WIDTH / 8,
   localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                  s00_axis_aclk,
   input  logic                  s00_axis_aresetn,
   eth_tx_arbiter_if.slave       s_axis,
   eth_tx_arbiter_if.master      m00_axis,
   input  logic [NUM_SRC*48-1:0] src_dst_mac_in,
   input  logic [NUM_SRC*16-1:0] src_eth_type_in,
   output logic [47:0]           dst_mac_addr_out,
   output logic [47:0]           eth_type_out,
   output logic [SRC_W-1:0]      grant_idx,
   output logic                  busy
);

   arb_state_t       state_q, state_d;
   logic [SRC_W-1:0] grant_q, last_grant_q, pick_idx;
   logic             any_req, load_grant, pkt_end;
   logic [47:0]      mac_q;
   logic [15:0]      type_q;
   logic             busy_q;

   rr_priority_pick #(.NUM_SRC(NUM_SRC)) u_pick (
      .req     (s_axis.tvalid),
      .last    (last_grant_q),
      .gnt_idx (pick_idx),
      .any_req (any_req)
   );

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) state_q <= IDLE;
      else                   state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      load_grant      = 1'b0;
      pkt_end         = 1'b0;
      s_axis.tready   = '0;
      m00_axis.tvalid = '0;
      m00_axis.tdata  = '0;
      m00_axis.tkeep  = '0;
      m00_axis.tlast  = '0;
      m00_axis.tuser  = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               load_grant = 1'b1;
               state_d    = GRANT;
            end
         end
         GRANT: state_d = STREAM;
         STREAM: begin
            m00_axis.tvalid        = s_axis.tvalid[grant_q];
            m00_axis.tdata         = s_axis.tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            m00_axis.tkeep         = s_axis.tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
            m00_axis.tlast         = s_axis.tlast[grant_q];
            m00_axis.tuser         = s_axis.tuser[int'(grant_q)*2 +: 2];
            s_axis.tready[grant_q] = m00_axis.tready;
            if (s_axis.tvalid[grant_q] && m00_axis.tready && s_axis.tlast[grant_q]) begin
               pkt_end = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Config registers only change at grant; they hold across the idle gap.
   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
         grant_q      <= '0;
         last_grant_q <= SRC_W'(NUM_SRC - 1);
         mac_q        <= '0;
         type_q       <= '0;
         busy_q       <= 1'b0;
      end else begin
         if (load_grant) begin
            grant_q <= pick_idx;
            mac_q   <= src_dst_mac_in[int'(pick_idx)*48 +: 48];
            type_q  <= src_eth_type_in[int'(pick_idx)*16 +: 16];
            busy_q  <= 1'b1;
         end
         if (pkt_end) begin
            last_grant_q <= grant_q;
            busy_q       <= 1'b0;
         end
      end
   end

   assign dst_mac_addr_out = mac_q;
   assign eth_type_out     = {32'h0, type_q};
   assign grant_idx        = grant_q;
   assign busy             = busy_q;

endmodule
